// File: rtl/cordic_pkg.sv
// Shared constants, widths and helpers for the polar-to-rectangular CORDIC.
// Angles are 2Q15 internally; x/y carry two guard integer bits and two extra fraction bits.
package cordic_pkg;

    localparam int XY_W  = 20;
    localparam int Z_W   = 18;
    localparam int CNT_W = 4;

    localparam logic signed [15:0]    INV_GAIN_Q14 = 16'sd9949;
    localparam logic signed [Z_W-1:0] HALF_PI_Q15  = 18'sd51472;

    // round(atan(2^-i) * 2^15)
    localparam logic signed [Z_W-1:0] ATAN_LUT [0:15] = '{
        18'sd25736, 18'sd15193, 18'sd8027, 18'sd4075,
        18'sd2045,  18'sd1024,  18'sd512,  18'sd256,
        18'sd128,   18'sd64,    18'sd32,   18'sd16,
        18'sd8,     18'sd4,     18'sd2,    18'sd1
    };

    localparam logic signed [XY_W:0] RND_HALF = 21'sd2;
    localparam logic signed [XY_W:0] SAT_HI   = 21'sd32767;
    localparam logic signed [XY_W:0] SAT_LO   = -21'sd32768;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    // Drop the two extra fraction bits with round-half-up, then clamp to 16 bits.
    function automatic logic [15:0] round_sat16(input logic signed [XY_W-1:0] v);
        logic signed [XY_W:0] t;
        t = v;
        t = (t + RND_HALF) >>> 2;
        if (t > SAT_HI)
            return 16'h7FFF;
        else if (t < SAT_LO)
            return 16'h8000;
        return 16'(t);
    endfunction

endpackage

// File: rtl/cordic_rotate_step.sv
// One channel of the rotation-mode CORDIC: prescale and quadrant fold on load,
// one micro-rotation per step, registered round/saturate of the final vector.
module cordic_rotate_step
    import cordic_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_capture,
    input  logic [CNT_W-1:0] i_iter,
    input  logic [31:0]      i_word,
    output logic [31:0]      o_word
);

    logic signed [XY_W-1:0] r_x, r_y;
    logic signed [Z_W-1:0]  r_z;
    logic [31:0]            r_word;

    logic signed [15:0]     w_mag, w_phase;
    logic signed [31:0]     w_prod;
    logic signed [XY_W-1:0] w_mscaled, w_x0, w_y0, w_xs, w_ys, w_x_nx, w_y_nx;
    logic signed [Z_W-1:0]  w_zin, w_z0, w_z_nx;

    always_comb begin
        w_mag     = i_word[15:0];
        w_phase   = i_word[31:16];
        w_prod    = 32'(w_mag) * 32'(INV_GAIN_Q14);
        w_mscaled = XY_W'((w_prod >>> 14) <<< 2);
        w_zin     = {w_phase, 2'b00};
        // Pre-rotate by +/-pi/2 so the residual angle is within CORDIC convergence.
        if (w_zin > HALF_PI_Q15) begin
            w_x0 = '0;
            w_y0 = w_mscaled;
            w_z0 = w_zin - HALF_PI_Q15;
        end else if (w_zin < -HALF_PI_Q15) begin
            w_x0 = '0;
            w_y0 = -w_mscaled;
            w_z0 = w_zin + HALF_PI_Q15;
        end else begin
            w_x0 = w_mscaled;
            w_y0 = '0;
            w_z0 = w_zin;
        end
    end

    always_comb begin
        w_xs = r_x >>> i_iter;
        w_ys = r_y >>> i_iter;
        if (r_z >= 0) begin
            w_x_nx = r_x - w_ys;
            w_y_nx = r_y + w_xs;
            w_z_nx = r_z - ATAN_LUT[i_iter];
        end else begin
            w_x_nx = r_x + w_ys;
            w_y_nx = r_y - w_xs;
            w_z_nx = r_z + ATAN_LUT[i_iter];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_word <= '0;
        end else begin
            if (i_load) begin
                r_x <= w_x0;
                r_y <= w_y0;
                r_z <= w_z0;
            end else if (i_step) begin
                r_x <= w_x_nx;
                r_y <= w_y_nx;
                r_z <= w_z_nx;
            end
            if (i_capture)
                r_word <= {round_sat16(r_y), round_sat16(r_x)};
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/polar_to_rect.sv
// Multi-channel polar (mag, phase) to rectangular (X, Y) converter with
// valid/ready on both sides; all channels rotate in lockstep.
//
//   state | meaning
//   IDLE  | ready_out high, waiting for valid_in
//   LOAD  | prescale + quadrant fold into x/y/z
//   ITER  | one micro-rotation per cycle, counter 0..ITERATIONS-1
//   DONE  | capture rounded result, then hold valid_out until ready_in
module polar_to_rect
    import cordic_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ITERATIONS = 14
)(
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic                           valid_in,
    output logic                           ready_out,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           valid_out,
    input  logic                           ready_in
);

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITERATIONS - 1);

    state_t                          r_state, w_state_nx;
    logic [CNT_W-1:0]                r_iter;
    logic [CHANNELS*DATA_WIDTH-1:0]  r_data;
    logic                            r_valid_out;
    logic                            w_accept, w_load, w_step, w_capture;

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            IDLE: if (valid_in) begin
                w_accept   = 1'b1;
                w_state_nx = LOAD;
            end
            LOAD: begin
                w_load     = 1'b1;
                w_state_nx = ITER;
            end
            ITER: begin
                w_step = 1'b1;
                if (r_iter == ITER_LAST)
                    w_state_nx = DONE;
            end
            DONE: begin
                // First DONE cycle registers the output; handshake only after that.
                if (!r_valid_out)
                    w_capture = 1'b1;
                else if (ready_in)
                    w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_iter      <= '0;
            r_data      <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept)
                r_data <= data_in;
            if (w_load)
                r_iter <= '0;
            else if (w_step)
                r_iter <= r_iter + 1'b1;
            if (w_capture)
                r_valid_out <= 1'b1;
            else if (r_valid_out && ready_in)
                r_valid_out <= 1'b0;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        cordic_rotate_step u_step (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .i_load    (w_load),
            .i_step    (w_step),
            .i_capture (w_capture),
            .i_iter    (r_iter),
            .i_word    (r_data[DATA_WIDTH*g +: DATA_WIDTH]),
            .o_word    (data_out[DATA_WIDTH*g +: DATA_WIDTH])
        );
    end

    assign ready_out = (r_state == IDLE);
    assign valid_out = r_valid_out;

endmodule

// File: tb/tb_polar_to_rect.sv
// Scoreboard bench for polar_to_rect: a real-valued trigonometric model queues
// expected X/Y at each accept; a monitor checks every result as it appears.
module tb_polar_to_rect;

    localparam int CH  = 4;
    localparam int DW  = 32;
    localparam int IT  = 14;
    localparam int LAT = IT + 2;

    logic              clk_in   = 1'b0;
    logic              rst_in   = 1'b1;
    logic              valid_in = 1'b0;
    logic              ready_in = 1'b1;
    logic [CH*DW-1:0]  data_in  = '0;
    logic              ready_out, valid_out;
    logic [CH*DW-1:0]  data_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_out = 0;
    int exp_q[$];
    int tol_q[$];
    int acc_q[$];
    logic prev_v = 1'b0;

    polar_to_rect #(.CHANNELS(CH), .DATA_WIDTH(DW), .ITERATIONS(IT)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        n_vec++;
        if (act < exp - tol || act > exp + tol) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    function automatic int ref_coord(input int mag, input int ph, input bit is_y);
        real m, a, v;
        m = mag / 16384.0;
        a = ph / 8192.0;
        v = (is_y ? m * $sin(a) : m * $cos(a)) * 16384.0;
        v = $floor(v + 0.5);
        if (v > 32767.0)  v = 32767.0;
        if (v < -32768.0) v = -32768.0;
        return $rtoi(v);
    endfunction

    function automatic logic [CH*DW-1:0] mk(input int m0, p0, m1, p1, m2, p2, m3, p3);
        logic [CH*DW-1:0] w;
        w = {16'(p3), 16'(m3), 16'(p2), 16'(m2), 16'(p1), 16'(m1), 16'(p0), 16'(m0)};
        return w;
    endfunction

    function automatic int rnd_mag();
        return int'($urandom_range(0, 49151)) - 24576;
    endfunction

    function automatic int rnd_ph();
        return int'($urandom_range(0, 51472)) - 25736;
    endfunction

    // tol < 0: out-of-contract input, only latency/completion is checked.
    task automatic send(input logic [CH*DW-1:0] word, input int tol);
        logic signed [15:0] m, p;
        int ex[2*CH];
        bit got;
        for (int c = 0; c < CH; c++) begin
            m = word[DW*c +: 16];
            p = word[DW*c+16 +: 16];
            ex[2*c]   = ref_coord(int'(m), int'(p), 1'b0);
            ex[2*c+1] = ref_coord(int'(m), int'(p), 1'b1);
        end
        @(negedge clk_in);
        data_in  = word;
        valid_in = 1'b1;
        got      = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (ready_out) begin
                @(posedge clk_in);
                got = 1'b1;
            end else begin
                @(negedge clk_in);
            end
        end
        if (!got) begin
            chk("accept_timeout", 0, 1, 0);
            valid_in = 1'b0;
            return;
        end
        @(negedge clk_in);
        valid_in = 1'b0;
        acc_q.push_back(cyc);
        tol_q.push_back(tol);
        for (int i = 0; i < 2*CH; i++) exp_q.push_back(ex[i]);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && acc_q.size() != 0; k++) @(negedge clk_in);
        chk("drain_pending", acc_q.size(), 0, 0);
        @(negedge clk_in);
    endtask

    always @(negedge clk_in) begin : monitor
        int tol, ex, ey;
        logic signed [15:0] ax, ay;
        if (rst_in) begin
            prev_v <= 1'b0;
        end else begin
            if (valid_out && !prev_v) begin
                n_out <= n_out + 1;
                if (acc_q.size() == 0) begin
                    chk("unexpected_output", 1, 0, 0);
                end else begin
                    chk("latency", cyc - acc_q.pop_front(), LAT, 0);
                    tol = tol_q.pop_front();
                    for (int c = 0; c < CH; c++) begin
                        ex = exp_q.pop_front();
                        ey = exp_q.pop_front();
                        ax = data_out[DW*c +: 16];
                        ay = data_out[DW*c+16 +: 16];
                        if (tol >= 0) begin
                            chk($sformatf("ch%0d_x", c), int'(ax), ex, tol);
                            chk($sformatf("ch%0d_y", c), int'(ay), ey, tol);
                        end
                    end
                end
            end
            prev_v <= valid_out;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

    initial begin : stim
        logic [CH*DW-1:0] held;
        int base_out;
        bit seen;

        // Reset state, with valid_in asserted during reset
        valid_in = 1'b1;
        data_in  = mk(16384, 0, 16384, 0, 16384, 0, 16384, 0);
        repeat (3) @(negedge clk_in);
        chk("rst_ready_out", int'(ready_out), 1, 0);
        chk("rst_valid_out", int'(valid_out), 0, 0);
        chk("rst_data_zero", int'(data_out == '0), 1, 0);
        valid_in = 1'b0;
        rst_in   = 1'b0;
        @(negedge clk_in);
        chk("post_rst_idle", int'(ready_out), 1, 0);

        // Basic rotation and quadrant folds
        send(mk(16384, 0, 16384, 12868, 16384, 25736, 8192, -6434), 4);
        drain();

        // Saturation, including the -32768 magnitude
        send(mk(-32768, 0, 0, 0, 32767, 0, -32768, 25736), 4);
        drain();
        chk("sat_x_negative", int'(data_out[15]), 1, 0);

        // Backpressure: hold in DONE for 10 cycles
        ready_in = 1'b0;
        send(mk(12000, 3000, -9000, -20000, 5000, 20000, 16384, -12868), 4);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk_in);
            seen = valid_out;
        end
        chk("bp_valid_seen", int'(seen), 1, 0);
        held = data_out;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            chk("bp_valid_hold", int'(valid_out), 1, 0);
            chk("bp_data_hold", int'(data_out == held), 1, 0);
            chk("bp_ready_low", int'(ready_out), 0, 0);
        end
        ready_in = 1'b1;
        @(negedge clk_in);
        chk("bp_release_valid", int'(valid_out), 0, 0);
        chk("bp_release_ready", int'(ready_out), 1, 0);
        drain();

        // Busy rejection: a second request during ITER must be ignored
        base_out = n_out;
        send(mk(10000, 1000, 10000, 2000, 10000, 3000, 10000, 4000), 4);
        repeat (4) @(negedge clk_in);
        data_in  = mk(-20000, -15000, -20000, 15000, 3000, 0, 0, 0);
        valid_in = 1'b1;
        chk("busy_ready_low", int'(ready_out), 0, 0);
        repeat (3) @(negedge clk_in);
        valid_in = 1'b0;
        drain();
        repeat (25) @(negedge clk_in);
        chk("busy_single_output", n_out - base_out, 1, 0);

        // Reset during iteration 5
        send(mk(20000, 5000, -20000, 5000, 20000, -5000, -20000, -5000), 4);
        repeat (6) @(negedge clk_in);
        rst_in = 1'b1;
        acc_q.delete();
        tol_q.delete();
        exp_q.delete();
        #1;
        chk("midrst_valid_out", int'(valid_out), 0, 0);
        chk("midrst_data_zero", int'(data_out == '0), 1, 0);
        chk("midrst_ready_out", int'(ready_out), 1, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        send(mk(16384, 6434, 16384, -19302, 8192, 19302, 4096, -25000), 4);
        drain();

        // Out-of-contract phase must still complete
        send(mk(1000, 32767, 1000, -32768, -32768, 32767, 32767, -32768), -1);
        drain();

        // Random in-contract sweep
        for (int t = 0; t < 250; t++)
            send(mk(rnd_mag(), rnd_ph(), rnd_mag(), rnd_ph(),
                    rnd_mag(), rnd_ph(), rnd_mag(), rnd_ph()), 8);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
